// File: rtl/key_event_pkg.sv
// Shared types, default parameters and width helper for the key event conditioner.
package key_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } key_state_e;

    localparam int unsigned DEF_NUM_KEYS       = 4;
    localparam int unsigned DEF_SAMPLE_DIV     = 4000000;
    localparam int unsigned DEF_STABLE_SAMPLES = 2;
    localparam int unsigned DEF_PULSE_CYCLES   = 16;
    localparam int unsigned DEF_LONG_SAMPLES   = 25;
    localparam int unsigned DEF_ACTIVE_LOW     = 1;

    // Bits needed to hold values 0..num_vals-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned num_vals);
        return (num_vals < 2) ? 1 : $clog2(num_vals);
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: synchroniser, sample history, press/long FSM and three
// active-low pulse stretchers.
//
//   state        | meaning
//   -------------+----------------------------------------------------------
//   ST_IDLE      | debounced level released, waiting for a press
//   ST_PRESSED   | pressed, counting sample ticks towards a long press
//   ST_LONG_HELD | long press already reported, waiting for the release
module key_channel
    import key_event_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int unsigned PULSE_CYCLES   = DEF_PULSE_CYCLES,
    parameter int unsigned LONG_SAMPLES   = DEF_LONG_SAMPLES,
    parameter int unsigned ACTIVE_LOW     = DEF_ACTIVE_LOW
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_raw_i,
    input  logic tick_i,
    output logic level_o,
    output logic press_n_o,
    output logic release_n_o,
    output logic long_n_o
);

    localparam int unsigned PW = cnt_width(PULSE_CYCLES + 1);
    localparam int unsigned LW = cnt_width(LONG_SAMPLES + 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);
    localparam logic [LW-1:0] LONG_LAST  = LW'(LONG_SAMPLES);
    localparam logic RELEASED_RAW = (ACTIVE_LOW != 0);

    logic                      sync1_q, sync2_q;
    logic                      pressed;
    logic [STABLE_SAMPLES-1:0] hist_q, hist_d;
    logic                      level_q, level_d;
    key_state_e                state_q, state_d;
    logic [LW-1:0]             long_q, long_d;
    logic                      fire_press, fire_release, fire_long;
    logic [PW-1:0]             press_cnt_q, release_cnt_q, long_cnt_q;

    function automatic logic [PW-1:0] pulse_next(input logic fire, input logic [PW-1:0] cnt);
        if (fire)
            return PULSE_LOAD;
        return (cnt != '0) ? cnt - 1'b1 : cnt;
    endfunction

    always_comb begin
        pressed = RELEASED_RAW ? ~sync2_q : sync2_q;
        hist_d  = hist_q;
        if (tick_i) begin
            hist_d    = hist_q << 1;
            hist_d[0] = pressed;
        end
        // Level follows the history in the same edge that shifts the new sample in.
        level_d = level_q;
        if (tick_i && ((&hist_d) || (~|hist_d)) && (hist_d[0] != level_q))
            level_d = hist_d[0];
    end

    always_comb begin
        state_d      = state_q;
        long_d       = long_q;
        fire_press   = 1'b0;
        fire_release = 1'b0;
        fire_long    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_d && !level_q) begin
                    state_d    = ST_PRESSED;
                    fire_press = 1'b1;
                    long_d     = '0;
                end
            end
            ST_PRESSED: begin
                if (!level_d) begin
                    state_d      = ST_IDLE;
                    fire_release = 1'b1;
                end else if (tick_i) begin
                    long_d = long_q + 1'b1;
                    if (long_d == LONG_LAST) begin
                        state_d   = ST_LONG_HELD;
                        fire_long = 1'b1;
                    end
                end
            end
            ST_LONG_HELD: begin
                if (!level_d) begin
                    state_d      = ST_IDLE;
                    fire_release = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q       <= RELEASED_RAW;
            sync2_q       <= RELEASED_RAW;
            hist_q        <= '0;
            level_q       <= 1'b0;
            state_q       <= ST_IDLE;
            long_q        <= '0;
            press_cnt_q   <= '0;
            release_cnt_q <= '0;
            long_cnt_q    <= '0;
        end else begin
            sync1_q       <= key_raw_i;
            sync2_q       <= sync1_q;
            hist_q        <= hist_d;
            level_q       <= level_d;
            state_q       <= state_d;
            long_q        <= long_d;
            press_cnt_q   <= pulse_next(fire_press, press_cnt_q);
            release_cnt_q <= pulse_next(fire_release, release_cnt_q);
            long_cnt_q    <= pulse_next(fire_long, long_cnt_q);
        end
    end

    assign level_o     = level_q;
    assign press_n_o   = (press_cnt_q == '0);
    assign release_n_o = (release_cnt_q == '0);
    assign long_n_o    = (long_cnt_q == '0);

endmodule

// File: rtl/key_event_ctrl.sv
// N-channel push-button conditioner: shared sample prescaler feeding one
// key_channel per key.
module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter int unsigned NUM_KEYS       = DEF_NUM_KEYS,
    parameter int unsigned SAMPLE_DIV     = DEF_SAMPLE_DIV,
    parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int unsigned PULSE_CYCLES   = DEF_PULSE_CYCLES,
    parameter int unsigned LONG_SAMPLES   = DEF_LONG_SAMPLES,
    parameter int unsigned ACTIVE_LOW     = DEF_ACTIVE_LOW
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    input  logic [NUM_KEYS-1:0] iKEY,
    input  logic                iENABLE,
    output logic                oSAMPLE_TICK,
    output logic [NUM_KEYS-1:0] oKEY_LEVEL,
    output logic [NUM_KEYS-1:0] oPRESS_n,
    output logic [NUM_KEYS-1:0] oRELEASE_n,
    output logic [NUM_KEYS-1:0] oLONG_n
);

    localparam int unsigned DW = cnt_width(SAMPLE_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          tick_q, tick_d;

    // Disabling freezes the count; the pulse stretchers keep running off iCLK.
    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        if (iENABLE) begin
            tick_d = (div_q == DIV_LAST);
            div_d  = tick_d ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign oSAMPLE_TICK = tick_q;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_channel #(
            .STABLE_SAMPLES(STABLE_SAMPLES),
            .PULSE_CYCLES  (PULSE_CYCLES),
            .LONG_SAMPLES  (LONG_SAMPLES),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_ch (
            .clk_i      (iCLK),
            .rst_ni     (iRST_n),
            .key_raw_i  (iKEY[g]),
            .tick_i     (tick_q),
            .level_o    (oKEY_LEVEL[g]),
            .press_n_o  (oPRESS_n[g]),
            .release_n_o(oRELEASE_n[g]),
            .long_n_o   (oLONG_n[g])
        );
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Scoreboard bench for key_event_ctrl: an event-time reference model pushes the
// expected output snapshot each cycle, a monitor pops and compares it.
module tb_key_event_ctrl;

    localparam int NK  = 4;
    localparam int DIV = 4;
    localparam int SS  = 2;
    localparam int PC  = 3;
    localparam int LS  = 5;
    localparam int AL  = 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b1;
    logic [NK-1:0] key   = '1;
    logic          tick;
    logic [NK-1:0] lvl, press_n, rel_n, long_n;

    key_event_ctrl #(
        .NUM_KEYS(NK), .SAMPLE_DIV(DIV), .STABLE_SAMPLES(SS),
        .PULSE_CYCLES(PC), .LONG_SAMPLES(LS), .ACTIVE_LOW(AL)
    ) dut (
        .iCLK(clk), .iRST_n(rst_n), .iKEY(key), .iENABLE(en),
        .oSAMPLE_TICK(tick), .oKEY_LEVEL(lvl), .oPRESS_n(press_n),
        .oRELEASE_n(rel_n), .oLONG_n(long_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          tick;
        logic [NK-1:0] lvl;
        logic [NK-1:0] press_n;
        logic [NK-1:0] rel_n;
        logic [NK-1:0] long_n;
    } obs_t;

    obs_t exp_q[$];
    obs_t e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: cycle index, enabled-cycle phase, sample queues and
    // pulse end times rather than counters.
    int  cyc;
    int  phase;
    bit  m_tick;
    bit  raw_d1[NK], raw_d2[NK];
    int  hist[NK][$];
    bit  m_lvl[NK];
    int  held_ticks[NK];
    bit  long_done[NK];
    int  press_end[NK], rel_end[NK], long_end[NK];

    function automatic void model_reset();
        cyc    = 0;
        phase  = 0;
        m_tick = 1'b0;
        for (int k = 0; k < NK; k++) begin
            raw_d1[k] = (AL != 0);
            raw_d2[k] = (AL != 0);
            hist[k].delete();
            for (int i = 0; i < SS; i++) hist[k].push_back(0);
            m_lvl[k]      = 1'b0;
            held_ticks[k] = 0;
            long_done[k]  = 1'b0;
            press_end[k]  = 0;
            rel_end[k]    = 0;
            long_end[k]   = 0;
        end
    endfunction

    function automatic void model_step();
        int  p;
        bit  same;
        cyc++;
        for (int k = 0; k < NK; k++) begin
            p = (AL != 0) ? int'(!raw_d2[k]) : int'(raw_d2[k]);
            if (m_tick) begin
                hist[k].push_back(p);
                if (hist[k].size() > SS) void'(hist[k].pop_front());
                same = 1'b1;
                foreach (hist[k][i]) if (hist[k][i] != p) same = 1'b0;
                if (same && (p != int'(m_lvl[k]))) begin
                    m_lvl[k] = (p != 0);
                    if (p != 0) begin
                        press_end[k]  = cyc + PC;
                        held_ticks[k] = 0;
                        long_done[k]  = 1'b0;
                    end else begin
                        rel_end[k] = cyc + PC;
                    end
                end else if (m_lvl[k] && !long_done[k]) begin
                    held_ticks[k]++;
                    if (held_ticks[k] == LS) begin
                        long_done[k] = 1'b1;
                        long_end[k]  = cyc + PC;
                    end
                end
            end
            raw_d2[k] = raw_d1[k];
            raw_d1[k] = key[k];
        end
        m_tick = en && (phase == DIV - 1);
        if (en) phase = (phase + 1) % DIV;
    endfunction

    function automatic obs_t snapshot();
        obs_t o;
        o.tick = m_tick;
        for (int k = 0; k < NK; k++) begin
            o.lvl[k]     = m_lvl[k];
            o.press_n[k] = !(cyc < press_end[k]);
            o.rel_n[k]   = !(cyc < rel_end[k]);
            o.long_n[k]  = !(cyc < long_end[k]);
        end
        return o;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
            exp_q.delete();
        end else begin
            model_step();
        end
        exp_q.push_back(snapshot());
    end

    task automatic check(input string nm, input logic [NK-1:0] act, input logic [NK-1:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, expv);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sample_tick", NK'(tick), NK'(e.tick));
            check("key_level",   lvl,     e.lvl);
            check("press_n",     press_n, e.press_n);
            check("release_n",   rel_n,   e.rel_n);
            check("long_n",      long_n,  e.long_n);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_press(input int k, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (!press_n[k]) seen = 1'b1;
        end
        check("wait_press", NK'(seen), NK'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        rst_n = 1'b0; en = 1'b1; key = '1;
        step(5);
        rst_n = 1'b1;
        step(24);

        // Clean press and later release on key 0
        key[0] = 1'b0;
        step(12);
        key[0] = 1'b1;
        step(16);

        // Bounce on key 1, alternating every tick
        for (int i = 0; i < 10; i++) begin
            key[1] = ~key[1];
            step(DIV);
        end
        key[1] = 1'b1;
        step(16);

        // Long press then release on key 2
        key[2] = 1'b0;
        step(10 * DIV + 8);
        key[2] = 1'b1;
        step(20);

        // Enable freeze with a press pulse in flight on key 3
        key[3] = 1'b0;
        wait_press(3, 40);
        en = 1'b0;
        step(14);
        en = 1'b1;
        step(8);
        key[3] = 1'b1;
        step(24);

        // Asynchronous reset mid-pulse with key 3 held
        key[3] = 1'b0;
        wait_press(3, 40);
        #2 rst_n = 1'b0;
        #1 check("async_reset_press_n", press_n, '1);
        check("async_reset_level", lvl, '0);
        step(3);
        rst_n = 1'b1;
        wait_press(3, 20);
        step(8);
        key[3] = 1'b1;
        step(20);

        // Simultaneous events on all channels
        key = '0;
        step(12);
        key = '1;
        step(16);

        // Randomised key activity, glitches and enable drops
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 3) == 0) key[k] = ~key[k];
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 4) == 0) begin
                int g = $urandom_range(0, NK - 1);
                key[g] = ~key[g];
                step($urandom_range(1, 3));
                key[g] = ~key[g];
            end
            step($urandom_range(2, 14));
        end
        en  = 1'b1;
        key = '1;
        step(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
